uart_rx_buffer: RTL
===================

# uart_rx_buffer

Receive-side consumer for the serial path. Captures each completed character from the UART receiver, queues it in a small FIFO, and offers it to the terminal logic on a show-ahead read port. It also requests XOFF/XON flow-control characters, which arbitration logic on the transmit side sends. It sits between the UART receiver and the terminal character decoder.

## Interface
- `DEPTH`, 16: FIFO entries; a power of two, 4..256.
- `AW`, 4: log2(`DEPTH`).
- `XOFF_LEVEL`, 12: request XOFF when occupancy reaches or exceeds this value.
- `XON_LEVEL`, 4: request XON when occupancy falls to or below this value. Must be less than `XOFF_LEVEL`.
- `FLOW`, 1: 0 disables flow control; `fc_req` is then held at 0.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `rx_done` in 1: receiver character-done level. A 0→1 transition marks a completed character.
- `rx_data` in [8:1]: received character; valid when `rx_done` rises.
- `rd` in 1: pop the head entry. Honoured only when `rd_valid` is 1.
- `rd_data` out [8:1]: head entry. Meaningful only while `rd_valid` is 1.
- `rd_valid` out 1: FIFO is non-empty.
- `count` out [AW:0]: current occupancy, 0..`DEPTH`.
- `overrun` out 1: sticky flag; a character was dropped because the FIFO was full.
- `overrun_clr` in 1: clears `overrun`.
- `fc_req` out 1: flow-control character pending; held high until acknowledged.
- `fc_char` out [8:1]: 8'o023 (XOFF) or 8'o021 (XON). Stable while `fc_req` is 1.
- `fc_ack` in 1: single-cycle pulse; the transmit side has accepted `fc_char`.

## Operation
- **Edge detect.** `rx_done0` registers `rx_done`; reset loads it with 1. `cap = rx_done & ~rx_done0`. Because of the reset value, `rx_done` sitting high out of reset produces no capture.
- **Write.** On `cap`, `rx_data` is written at `wp`, and `wp` advances modulo `DEPTH`.
- **Read.** On `rd & rd_valid`, `rp` advances modulo `DEPTH`.
- **`count` update:**
  - +1 on a write alone.
  - −1 on a read alone.
  - Unchanged on a simultaneous write and read.
- **Full.** When full, `cap` together with a valid `rd` is accepted; `count` stays at `DEPTH`. `cap` without `rd` drops the byte, leaves `count` and `wp` unchanged, and sets `overrun`.
- **Empty.** `rd` while empty is ignored. `cap` while empty writes; `rd_valid` rises the next cycle.
- **`overrun` precedence.** If a new overrun and `overrun_clr` occur in the same cycle, the set wins.
- **Flow FSM** (all transitions evaluated against registered `count`):
  - `FLOW_ON`: if `count >= XOFF_LEVEL`, go to `SEND_XOFF`.
  - `SEND_XOFF`: `fc_req`=1, `fc_char`=023. On `fc_ack`, go to `FLOW_OFF`. An XOFF request is never withdrawn, even if `count` drops meanwhile.
  - `FLOW_OFF`: if `count <= XON_LEVEL`, go to `SEND_XON`.
  - `SEND_XON`: `fc_req`=1, `fc_char`=021. On `fc_ack`, go to `FLOW_ON`.
  - `fc_ack` in `FLOW_ON` or `FLOW_OFF` is ignored.
- **Reset values:**
  - `wp`, `rp`, `count` = 0.
  - `rd_valid` = 0, `overrun` = 0.
  - FSM = `FLOW_ON`, `fc_req` = 0, `fc_char` = 021.
  - `rx_done0` = 1.
  - FIFO contents are not cleared.
- **Reset mid-character.** A character in progress is discarded. A pending `fc_req` drops the cycle after reset.

## Timing
- Capture latency: `rx_done` sampled high at edge N (low at N−1) → entry written at edge N → `rd_valid`=1 and `rd_data` valid after edge N.
- `rd_data` is show-ahead. After a pop at edge N, the next entry appears after edge N. Reading from storage is combinational on `rp`.
- `count`, `rd_valid`, `overrun` and `fc_req` are registered. `count` reflects the operation at edge N from edge N onward.
- `fc_req` rises one cycle after `count` crosses the threshold and falls the cycle after `fc_ack`.
- Throughput: one write and one read per cycle. `cap` can fire at most once per character time.

## Structure
- Shared package `uart_pkg` holds:
  - `XON_CHAR` = 8'o021 and `XOFF_CHAR` = 8'o023.
  - Flow FSM state encoding (2 bits: `FLOW_ON`, `SEND_XOFF`, `FLOW_OFF`, `SEND_XON`).
- One sub-module, `uart_fifo_mem`: `DEPTH`×8 storage with a synchronous write and an asynchronous read port. Pointers, count and the FSM stay in the top level.

## Test plan
- **Basic order.** Reset, then `rx_done` pulses carrying 8'h41, 8'h42 → `rd_valid`=1 one edge after the first rise, `rd_data`=41. After `rd`, `rd_data`=42. After a second `rd`, `rd_valid`=0 and `count`=0.
- **No spurious capture.** Hold `rx_done`=1 through and after reset, with no falling edge → `count` stays 0.
- **Overrun.** Write 17 chars 0x00..0x10 with no reads (`DEPTH`=16) → `count`=16 and `overrun`=1. Draining gives 0x00..0x0F; 0x10 is lost. A cycle with both `overrun_clr` and an overflowing `cap` leaves `overrun`=1.
- **Full read/write.** At full, `cap`(8'h55) together with `rd` → `count` stays 16, the head advances, and 55 is read last.
- **Flow control.** Fill to 12 → `fc_req`=1, `fc_char`=023; `fc_ack` → `fc_req`=0. Drain to 5 → no request. Drain to 4 → `fc_req`=1, `fc_char`=021; `fc_ack` → `FLOW_ON`.
- **Reset mid-use.** Assert `reset` with `count`=7 and `fc_req`=1 → next cycle `count`=0, `rd_valid`=0, `fc_req`=0, `overrun`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: flow-control characters and the flow FSM encoding.
package uart_pkg;

    localparam logic [8:1] XON_CHAR  = 8'o021;
    localparam logic [8:1] XOFF_CHAR = 8'o023;

    typedef enum logic [1:0] {
        FLOW_ON   = 2'd0,
        SEND_XOFF = 2'd1,
        FLOW_OFF  = 2'd2,
        SEND_XON  = 2'd3
    } flow_state_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Bus between the UART receiver / terminal decoder / TX arbiter and the RX buffer.
interface uart_rx_buffer_if #(
    parameter int AW = 4
);
    logic        rx_done;
    logic [8:1]  rx_data;
    logic        rd;
    logic [8:1]  rd_data;
    logic        rd_valid;
    logic [AW:0] count;
    logic        overrun;
    logic        overrun_clr;
    logic        fc_req;
    logic [8:1]  fc_char;
    logic        fc_ack;

    modport master (
        output rx_done, rx_data, rd, overrun_clr, fc_ack,
        input  rd_data, rd_valid, count, overrun, fc_req, fc_char
    );

    modport slave (
        input  rx_done, rx_data, rd, overrun_clr, fc_ack,
        output rd_data, rd_valid, count, overrun, fc_req, fc_char
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write, combinational (show-ahead) read.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:1]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [8:1]    rdata
);
    logic [8:1] mem [DEPTH];

    // Write port; contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_buffer.sv
// RX character buffer: edge-detected capture into a FIFO, show-ahead read
// port, sticky overrun flag and XOFF/XON flow-control request FSM.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int XOFF_LEVEL = 12,
    parameter int XON_LEVEL  = 4,
    parameter int FLOW       = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_buffer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] XOFF_CNT = (AW+1)'(XOFF_LEVEL);
    localparam logic [AW:0] XON_CNT  = (AW+1)'(XON_LEVEL);

    logic          rx_done0;
    logic          cap;
    logic          full;
    logic          rd_ok;
    logic          wr_ok;
    logic          drop;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next;
    logic          rd_valid_r;
    logic          overrun_r;
    flow_state_t   state;
    flow_state_t   state_next;

    // A full FIFO still accepts a character when a pop happens in the same cycle.
    assign cap   = bus.rx_done & ~rx_done0;
    assign full  = (count_r == FULL_CNT);
    assign rd_ok = bus.rd & rd_valid_r;
    assign wr_ok = cap & (~full | rd_ok);
    assign drop  = cap & full & ~rd_ok;

    assign bus.count    = count_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.overrun  = overrun_r;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (bus.rx_data),
        .raddr (rp),
        .rdata (bus.rd_data)
    );

    // Rising-edge detector; resets high so a level already high is not a character.
    always_ff @(posedge clk) begin
        if (reset)
            rx_done0 <= 1'b1;
        else
            rx_done0 <= bus.rx_done;
    end

    // Occupancy after this cycle's write/read.
    always_comb begin
        count_next = count_r;
        if (wr_ok && !rd_ok)
            count_next = count_r + 1'b1;
        else if (rd_ok && !wr_ok)
            count_next = count_r - 1'b1;
    end

    // Pointers, occupancy and non-empty flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_ok)
                wp <= wp + 1'b1;
            if (rd_ok)
                rp <= rp + 1'b1;
            count_r    <= count_next;
            rd_valid_r <= (count_next != '0);
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)
            overrun_r <= 1'b0;
        else if (drop)
            overrun_r <= 1'b1;
        else if (bus.overrun_clr)
            overrun_r <= 1'b0;
    end

    // Flow FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= FLOW_ON;
        else
            state <= state_next;
    end

    // Flow FSM transitions on registered count; request is a decode of the state.
    always_comb begin
        state_next  = state;
        bus.fc_req  = 1'b0;
        bus.fc_char = XON_CHAR;
        if (FLOW != 0) begin
            case (state)
                FLOW_ON: begin
                    if (count_r >= XOFF_CNT)
                        state_next = SEND_XOFF;
                end
                SEND_XOFF: begin
                    bus.fc_req  = 1'b1;
                    bus.fc_char = XOFF_CHAR;
                    if (bus.fc_ack)
                        state_next = FLOW_OFF;
                end
                FLOW_OFF: begin
                    bus.fc_char = XOFF_CHAR;
                    if (count_r <= XON_CNT)
                        state_next = SEND_XON;
                end
                SEND_XON: begin
                    bus.fc_req = 1'b1;
                    if (bus.fc_ack)
                        state_next = FLOW_ON;
                end
                default: state_next = FLOW_ON;
            endcase
        end
    end
endmodule
